// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: a valid/ready request side carrying
// a base instruction, an immediate and a format code, and a valid/ready result side.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic [2:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    // A beat moves on either side only in a cycle where valid and ready are both
    // high at the rising edge; a producer holds its payload until that happens.
    modport master (
        output in_valid, in_base, in_imm, ImmSrc, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_base, in_imm, ImmSrc, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U fields of an RV32I instruction,
// flags unrepresentable immediates and counts them. Two-stage valid/ready pipe.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_encoder_if.slave     bus,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);
    logic              r_s1_valid;
    logic [31:0]       r_s1_base;
    logic [31:0]       r_s1_imm;
    logic [2:0]        r_s1_src;
    logic              r_s1_bad;
    logic              r_s2_valid;
    logic [31:0]       r_out_inst;
    logic              r_out_err;
    logic [CNT_W-1:0]  r_err_count;

    logic              w_s2_adv;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_in_bad;
    logic signed [31:0] w_imm_s;
    logic [31:0]       w_pack;

    assign w_s2_adv      = !r_s2_valid || bus.out_ready;
    assign bus.in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_fire     = bus.in_valid && bus.in_ready;
    assign w_out_fire    = r_s2_valid && bus.out_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_err   = r_out_err;
    assign err_count     = r_err_count;
    assign w_imm_s       = signed'(bus.in_imm);

    // Representability is decided on the raw request so stage 2 only has to pack.
    always_comb begin
        w_in_bad = 1'b1;
        case (bus.ImmSrc)
            3'b000, 3'b001: w_in_bad = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
            3'b010: w_in_bad = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) || bus.in_imm[0];
            3'b011: w_in_bad = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574) || bus.in_imm[0];
            3'b100: w_in_bad = |bus.in_imm[11:0];
            default: w_in_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_pack = r_s1_base;
        case (r_s1_src)
            3'b000: w_pack[31:20] = r_s1_imm[11:0];
            3'b001: begin
                w_pack[31:25] = r_s1_imm[11:5];
                w_pack[11:7]  = r_s1_imm[4:0];
            end
            3'b010: begin
                w_pack[31]    = r_s1_imm[12];
                w_pack[7]     = r_s1_imm[11];
                w_pack[30:25] = r_s1_imm[10:5];
                w_pack[11:8]  = r_s1_imm[4:1];
            end
            3'b011: begin
                w_pack[31]    = r_s1_imm[20];
                w_pack[19:12] = r_s1_imm[19:12];
                w_pack[20]    = r_s1_imm[11];
                w_pack[30:21] = r_s1_imm[10:1];
            end
            3'b100: w_pack[31:12] = r_s1_imm[31:12];
            default: w_pack = r_s1_base;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_base  <= '0;
            r_s1_imm   <= '0;
            r_s1_src   <= '0;
            r_s1_bad   <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_base  <= bus.in_base;
            r_s1_imm   <= bus.in_imm;
            r_s1_src   <= bus.ImmSrc;
            r_s1_bad   <= w_in_bad;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Payload only reloads when a real beat arrives, so a stalled result never moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_inst <= '0;
            r_out_err  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_inst <= w_pack;
                r_out_err  <= r_s1_bad;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_out_fire && r_out_err && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule
